// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one NAND-built full adder stepped LSB-first over WIDTH cycles.
// Latency: start seen in cycle T -> done pulse in cycle T+WIDTH+1; next start accepted at T+WIDTH+2.
// Backpressure: none; start is only sampled in IDLE, and requests during RUN/DONE are dropped.

module nand_gate (
    input  logic x,
    input  logic y,
    output logic z
);
    assign z = ~(x & y);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Nine-NAND full adder over the current LSBs and the carry flop
    logic n1, n2, n3, axb, n5, n6, n7, fa_sum, fa_cout;

    nand_gate u_n1 (.x(a_sh[0]), .y(b_sh[0]), .z(n1));
    nand_gate u_n2 (.x(a_sh[0]), .y(n1),      .z(n2));
    nand_gate u_n3 (.x(b_sh[0]), .y(n1),      .z(n3));
    nand_gate u_n4 (.x(n2),      .y(n3),      .z(axb));
    nand_gate u_n5 (.x(axb),     .y(carry),   .z(n5));
    nand_gate u_n6 (.x(axb),     .y(n5),      .z(n6));
    nand_gate u_n7 (.x(carry),   .y(n5),      .z(n7));
    nand_gate u_n8 (.x(n6),      .y(n7),      .z(fa_sum));
    nand_gate u_n9 (.x(n1),      .y(n5),      .z(fa_cout));

    // Only the upper WIDTH-1 result bits need storage; the newest bit comes straight from the adder
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_nxt = fa_sum;
        end else begin : g_wn
            logic [WIDTH-2:0] res_sh;
            always_ff @(posedge clk) begin
                if (rst)
                    res_sh <= '0;
                else if (state == RUN)
                    res_sh <= res_nxt[WIDTH-1:1];
            end
            assign res_nxt = {fa_sum, res_sh};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum  <= res_nxt;
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
